lsb_queue: RTL
==============

Name: lsb_queue

Overview:
- Parametrised in-order load/store buffer for the out-of-order RISC-V core; next generation of the current single-size store/load buffer.
- Sits between dispatch, the common data bus (CDB), the ROB and the memory controller.
- Adds: configurable depth and tag width; a valid/ready memory handshake; a commit-gated store path; a self-bypass of its own load results; and a flush that keeps committed stores.

Parameters:
DEPTH, 16, entry count; power of two, >=2
TAG_W, 5, ROB tag width
AW, 4, log2(DEPTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global enable; low freezes all state
clear  in  1  pipeline flush from ROB
full  out  1  count==DEPTH
disp_valid  in  1  dispatch new entry at tail
disp_op  in  4  [3]=store, [2:0]=funct3
disp_vj / disp_vk  in  32  base / store-data value
disp_qj_v / disp_qk_v  in  1  operand pending
disp_qj / disp_qk  in  TAG_W  producer tag
disp_imm  in  32  offset
disp_tag  in  TAG_W  own ROB tag
cdb_valid  in  1  ALU broadcast
cdb_tag  in  TAG_W  ALU broadcast tag
cdb_value  in  32  ALU broadcast value
commit_valid  in  1  ROB commits a store
commit_tag  in  TAG_W  tag of the committed store
mem_req_valid  out  1  request
mem_req_ready  in  1  controller accepts
mem_req_we  out  1  store
mem_req_size  out  2  0=B, 1=H, 2=W
mem_req_addr  out  32  vj+imm
mem_req_wdata  out  32  vk
mem_resp_valid  in  1  response/ack, one cycle
mem_resp_data  in  32  raw load data
ld_out_valid  out  1  load result pulse
ld_out_tag  out  TAG_W  load's ROB tag
ld_out_value  out  32  extended load data
st_rdy_valid  out  1  head store operands resolved (pulse)
st_rdy_tag  out  TAG_W  that store's ROB tag

Behaviour:
- Circular queue with head, tail (AW bits, wrap modulo DEPTH) and count (AW+1 bits).
- Reset: head=tail=count=0; all entries invalid, committed=0; FSM=IDLE; every output 0.
- Dispatch: accepted only if disp_valid && !full; writes the entry at tail, then tail++.
  - Dispatch while full is dropped.
  - Same-cycle capture: if cdb_valid or ld_out_valid matches disp_qj/disp_qk, the entry stores the value with pending cleared.
- Wakeup: each cycle, every valid entry with a pending q equal to cdb_tag (cdb_valid) or ld_out_tag (ld_out_valid) takes the value and clears pending. Both sources may wake in the same cycle.
- Commit: commit_valid marks the entry whose tag==commit_tag committed.
- st_rdy: pulses exactly once per store, the first cycle that store is at head with both operands resolved.
- FSM:
  - IDLE: issue the head entry when count>0 and qj clear.
    - Loads issue when qj is clear.
    - Stores also need qk clear and committed.
    - On issue, drive mem_req_* (registered) -> REQ.
  - REQ: hold valid and all fields stable until mem_req_ready -> WAIT.
  - WAIT: on mem_resp_valid, pop head (head++, count--) -> IDLE.
    - For a load, next cycle: ld_out_valid=1, tag, value.
    - Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW pass-through.
- Lowest latency: load request 1 cycle after it reaches head with operands ready; result 1 cycle after mem_resp_valid.
- Simultaneous dispatch and pop: count unchanged; a full queue still rejects dispatch that cycle (full is registered).
- Flush (clear, rdy high):
  - Drop every uncommitted entry: tail = head + number of committed entries, count likewise. Committed stores are always contiguous from head.
  - An in-flight load: a drop flag discards its response; no ld_out pulse, and head is not popped again for it.
  - An in-flight store completes normally.
  - ld_out_valid and st_rdy_valid are suppressed that cycle.
- rdy low: no state change; pulse outputs forced 0; mem_req_* held.
- Async reset mid-transaction returns to the reset state immediately.

Test Plan:
- LW at head, base 0x100 ready, imm 4: mem_req addr=0x104, size=2 the next cycle; ready after 2 cycles; resp 0xDEADBEEF -> ld_out_value=0xDEADBEEF with the correct tag, count back to 0.
- LB, resp 0x00000080 -> ld_out_value 0xFFFFFF80; LBU -> 0x00000080.
- SW at head, operands ready -> single st_rdy pulse, no mem_req until commit_valid with its tag; then we=1, wdata correct; resp pops it.
- Load with qj=7 dispatched in the same cycle as cdb tag 7 value 0x40 -> captured; request addr 0x40+imm.
- Fill 16 entries -> full=1; 17th dispatch dropped; pop, then dispatch wraps tail to 0.
- Queue holds committed SW, uncommitted LW (in flight is SW), two more loads; clear -> count=1, store completes, later responses produce no ld_out.

Source files
------------

// File: rtl/lsb_queue.sv
// lsb_queue: in-order load/store buffer with commit-gated stores, memory handshake and load self-bypass
module lsb_queue #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 5,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  output logic             full,
  input  logic             disp_valid,
  input  logic [3:0]       disp_op,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  input  logic             disp_qj_v,
  input  logic             disp_qk_v,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic [31:0]      disp_imm,
  input  logic [TAG_W-1:0] disp_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             commit_valid,
  input  logic [TAG_W-1:0] commit_tag,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_we,
  output logic [1:0]       mem_req_size,
  output logic [31:0]      mem_req_addr,
  output logic [31:0]      mem_req_wdata,
  input  logic             mem_resp_valid,
  input  logic [31:0]      mem_resp_data,
  output logic             ld_out_valid,
  output logic [TAG_W-1:0] ld_out_tag,
  output logic [31:0]      ld_out_value,
  output logic             st_rdy_valid,
  output logic [TAG_W-1:0] st_rdy_tag
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state;
  logic [AW-1:0] head, tail;
  logic [AW:0] count, n_com;
  logic [DEPTH-1:0] e_valid, e_store, e_qj_v, e_qk_v, e_com, e_srd;
  logic [2:0] e_f3 [DEPTH];
  logic [31:0] e_vj [DEPTH];
  logic [31:0] e_vk [DEPTH];
  logic [31:0] e_imm [DEPTH];
  logic [TAG_W-1:0] e_qj [DEPTH];
  logic [TAG_W-1:0] e_qk [DEPTH];
  logic [TAG_W-1:0] e_tag [DEPTH];
  logic drop, ld_q;
  logic [2:0] cur_f3;
  logic [TAG_W-1:0] cur_tag;
  logic ld_fire, push, pop, resp_done, can_issue, st_fire;
  logic dj_c, dj_l, dk_c, dk_l;
  logic [31:0] ext;

  assign full = count[AW];
  assign ld_fire = ld_q & rdy & ~clear;
  assign ld_out_valid = ld_fire;
  assign st_fire = rdy & ~clear & e_valid[head] & e_store[head] & ~e_qj_v[head] & ~e_qk_v[head] & ~e_srd[head];
  assign st_rdy_valid = st_fire;
  assign st_rdy_tag = e_tag[head];
  assign resp_done = (state == WAIT) && mem_resp_valid;
  assign pop = resp_done & ~drop & (~clear | mem_req_we);
  assign push = disp_valid & ~full & ~clear;
  assign can_issue = (state == IDLE) && !clear && e_valid[head] && !e_qj_v[head] &&
                     (!e_store[head] || (!e_qk_v[head] && e_com[head]));
  assign dj_c = disp_qj_v & cdb_valid & (disp_qj == cdb_tag);
  assign dj_l = disp_qj_v & ld_fire & (disp_qj == ld_out_tag);
  assign dk_c = disp_qk_v & cdb_valid & (disp_qk == cdb_tag);
  assign dk_l = disp_qk_v & ld_fire & (disp_qk == ld_out_tag);
  assign ext = cur_f3 == 3'd0 ? {{24{mem_resp_data[7]}}, mem_resp_data[7:0]} :
               cur_f3 == 3'd1 ? {{16{mem_resp_data[15]}}, mem_resp_data[15:0]} :
               cur_f3 == 3'd4 ? {24'b0, mem_resp_data[7:0]} :
               cur_f3 == 3'd5 ? {16'b0, mem_resp_data[15:0]} : mem_resp_data;

  // committed stores are contiguous from head, so their total is the surviving length on flush
  always_comb begin
    n_com = '0;
    for (int i = 0; i < DEPTH; i++) n_com = n_com + (AW+1)'(e_valid[i] & e_com[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      drop <= 1'b0;
      ld_q <= 1'b0;
      cur_f3 <= '0;
      cur_tag <= '0;
      ld_out_tag <= '0;
      ld_out_value <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we <= 1'b0;
      mem_req_size <= '0;
      mem_req_addr <= '0;
      mem_req_wdata <= '0;
      e_valid <= '0;
      e_store <= '0;
      e_qj_v <= '0;
      e_qk_v <= '0;
      e_com <= '0;
      e_srd <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_f3[i] <= '0;
        e_vj[i] <= '0;
        e_vk[i] <= '0;
        e_imm[i] <= '0;
        e_qj[i] <= '0;
        e_qk[i] <= '0;
        e_tag[i] <= '0;
      end
    end else if (rdy) begin
      ld_q <= resp_done & ~drop & ~mem_req_we & ~clear;
      if (resp_done & ~drop & ~mem_req_we) begin
        ld_out_tag <= cur_tag;
        ld_out_value <= ext;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (e_qj_v[i] && cdb_valid && e_qj[i] == cdb_tag) begin
          e_vj[i] <= cdb_value;
          e_qj_v[i] <= 1'b0;
        end else if (e_qj_v[i] && ld_fire && e_qj[i] == ld_out_tag) begin
          e_vj[i] <= ld_out_value;
          e_qj_v[i] <= 1'b0;
        end
        if (e_qk_v[i] && cdb_valid && e_qk[i] == cdb_tag) begin
          e_vk[i] <= cdb_value;
          e_qk_v[i] <= 1'b0;
        end else if (e_qk_v[i] && ld_fire && e_qk[i] == ld_out_tag) begin
          e_vk[i] <= ld_out_value;
          e_qk_v[i] <= 1'b0;
        end
        if (commit_valid && e_valid[i] && e_tag[i] == commit_tag) e_com[i] <= 1'b1;
        if (clear && !e_com[i]) e_valid[i] <= 1'b0;
      end
      if (st_fire) e_srd[head] <= 1'b1;
      if (pop) e_valid[head] <= 1'b0;
      if (push) begin
        e_valid[tail] <= 1'b1;
        e_store[tail] <= disp_op[3];
        e_f3[tail] <= disp_op[2:0];
        e_vj[tail] <= dj_c ? cdb_value : dj_l ? ld_out_value : disp_vj;
        e_vk[tail] <= dk_c ? cdb_value : dk_l ? ld_out_value : disp_vk;
        e_qj_v[tail] <= disp_qj_v & ~dj_c & ~dj_l;
        e_qk_v[tail] <= disp_qk_v & ~dk_c & ~dk_l;
        e_qj[tail] <= disp_qj;
        e_qk[tail] <= disp_qk;
        e_imm[tail] <= disp_imm;
        e_tag[tail] <= disp_tag;
        e_com[tail] <= 1'b0;
        e_srd[tail] <= 1'b0;
      end
      if (clear) begin
        tail <= head + n_com[AW-1:0];
        count <= n_com - (AW+1)'(pop);
      end else begin
        tail <= tail + AW'(push);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
      if (pop) head <= head + AW'(1);
      if (can_issue) begin
        state <= REQ;
        mem_req_valid <= 1'b1;
        mem_req_we <= e_store[head];
        mem_req_size <= e_f3[head][1:0];
        mem_req_addr <= e_vj[head] + e_imm[head];
        mem_req_wdata <= e_vk[head];
        cur_f3 <= e_f3[head];
        cur_tag <= e_tag[head];
      end else if (state == REQ && mem_req_ready) begin
        state <= WAIT;
        mem_req_valid <= 1'b0;
      end else if (resp_done) begin
        state <= IDLE;
        drop <= 1'b0;
      end
      // a flushed load still owns the bus; its eventual response must be swallowed
      if (clear && !mem_req_we && (state == REQ || (state == WAIT && !mem_resp_valid))) drop <= 1'b1;
    end
  end
endmodule
